// File: rtl/rs_pkg.sv
// GF(2^m) helpers shared by the Reed-Solomon syndrome blocks.
// Used at elaboration time only, to derive constant multiplier networks.
package rs_pkg;

    localparam int unsigned RS_SYMBOL_WIDTH = 8;
    localparam logic [8:0]  RS_PRIM_POLY    = 9'h11D;
    localparam int unsigned GF_MAX_W        = 16;

    typedef logic [GF_MAX_W-1:0] gf_elem_t;
    typedef logic [GF_MAX_W:0]   gf_poly_t;

    function automatic gf_elem_t gf_mul(input gf_elem_t a, input gf_elem_t b,
                                        input gf_poly_t poly, input int unsigned m);
        gf_poly_t x;
        gf_poly_t p;
        x = {1'b0, a};
        p = '0;
        for (int unsigned i = 0; i < m; i++) begin
            if (b[i]) p ^= x;
            x = x << 1;
            if (x[m]) x ^= poly;
        end
        return p[GF_MAX_W-1:0];
    endfunction

    function automatic gf_elem_t gf_alpha_pow(input int unsigned e, input gf_poly_t poly,
                                              input int unsigned m);
        gf_elem_t r;
        r = gf_elem_t'(1);
        for (int unsigned i = 0; i < e; i++)
            r = gf_mul(r, gf_elem_t'(2), poly, m);
        return r;
    endfunction

endpackage

// File: rtl/rs_gf_cmul.sv
// Multiply a GF(2^m) symbol by the constant alpha^EXP.
// Each input bit selects a precomputed column, so the result is a pure XOR network.
module rs_gf_cmul
    import rs_pkg::*;
#(
    parameter int unsigned            SYMBOL_WIDTH = RS_SYMBOL_WIDTH,
    parameter logic [SYMBOL_WIDTH:0]  PRIM_POLY    = RS_PRIM_POLY,
    parameter int unsigned            EXP          = 1
) (
    input  logic [SYMBOL_WIDTH-1:0] in_sym,
    output logic [SYMBOL_WIDTH-1:0] out_sym
);

    localparam gf_elem_t K = gf_alpha_pow(EXP, gf_poly_t'(PRIM_POLY), SYMBOL_WIDTH);

    logic [SYMBOL_WIDTH-1:0] terms [SYMBOL_WIDTH];

    for (genvar i = 0; i < SYMBOL_WIDTH; i++) begin : g_col
        localparam logic [SYMBOL_WIDTH-1:0] COL =
            SYMBOL_WIDTH'(gf_mul(K, gf_elem_t'(1) << i, gf_poly_t'(PRIM_POLY), SYMBOL_WIDTH));
        assign terms[i] = in_sym[i] ? COL : '0;
    end

    always_comb begin
        out_sym = '0;
        for (int unsigned i = 0; i < SYMBOL_WIDTH; i++)
            out_sym ^= terms[i];
    end

endmodule

// File: rtl/rs_syndrome_seq.sv
// Streaming RS syndrome calculator: Horner evaluation at NSYN consecutive roots.
// Optional SOP framing with abort reporting when RS_SYN_FRAMING_EN is defined.
module rs_syndrome_seq
    import rs_pkg::*;
#(
    parameter int unsigned            SYMBOL_WIDTH = RS_SYMBOL_WIDTH,
    parameter int unsigned            N            = 18,
    parameter int unsigned            NSYN         = 2,
    parameter int unsigned            FCR          = 1,
    parameter logic [SYMBOL_WIDTH:0]  PRIM_POLY    = RS_PRIM_POLY
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [SYMBOL_WIDTH-1:0]      in_data,
`ifdef RS_SYN_FRAMING_EN
    input  logic                         in_sop,
    output logic                         frame_err,
`endif
    output logic                         syn_valid,
    input  logic                         syn_ready,
    output logic [NSYN*SYMBOL_WIDTH-1:0] syn_out,
    output logic                         syn_zero
);

    localparam int unsigned CW = $clog2(N);

    logic [CW-1:0]           cnt, cnt_d;
    logic [SYMBOL_WIDTH-1:0] acc     [NSYN];
    logic [SYMBOL_WIDTH-1:0] acc_mul [NSYN];
    logic [SYMBOL_WIDTH-1:0] acc_d   [NSYN];
    logic [NSYN*SYMBOL_WIDTH-1:0] syn_d;
    logic all_zero, cnt_zero, cnt_last, xfer, first, accept, complete;

    for (genvar j = 0; j < NSYN; j++) begin : g_syn
        rs_gf_cmul #(
            .SYMBOL_WIDTH (SYMBOL_WIDTH),
            .PRIM_POLY    (PRIM_POLY),
            .EXP          (FCR + j)
        ) u_cmul (
            .in_sym  (acc[j]),
            .out_sym (acc_mul[j])
        );
    end

    assign cnt_zero = (cnt == '0);
    assign cnt_last = (cnt == CW'(N - 1));
    assign in_ready = !(cnt_last && syn_valid && !syn_ready);
    assign xfer     = in_valid && in_ready;

`ifdef RS_SYN_FRAMING_EN
    // SOP restarts the codeword; a non-SOP symbol with no codeword open is dropped.
    assign first    = in_sop;
    assign accept   = xfer && (in_sop || !cnt_zero);
    assign complete = xfer && !in_sop && cnt_last;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) frame_err <= 1'b0;
        else        frame_err <= xfer && ((in_sop && !cnt_zero) || (!in_sop && cnt_zero));
    end
`else
    assign first    = cnt_zero;
    assign accept   = xfer;
    assign complete = xfer && cnt_last;
`endif

    always_comb begin
        cnt_d = cnt;
        if (accept)
            cnt_d = first ? CW'(1) : (cnt_last ? '0 : cnt + 1'b1);
    end

    always_comb begin
        syn_d    = '0;
        all_zero = 1'b1;
        for (int unsigned j = 0; j < NSYN; j++) begin
            acc_d[j] = (first ? '0 : acc_mul[j]) ^ in_data;
            syn_d[(NSYN-j)*SYMBOL_WIDTH-1 -: SYMBOL_WIDTH] = acc_d[j];
            if (acc_d[j] != '0) all_zero = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
            for (int unsigned j = 0; j < NSYN; j++) acc[j] <= '0;
        end else if (accept) begin
            cnt <= cnt_d;
            for (int unsigned j = 0; j < NSYN; j++) acc[j] <= acc_d[j];
        end
    end

    // New result may replace a consumed one in the same cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            syn_valid <= 1'b0;
            syn_out   <= '0;
            syn_zero  <= 1'b0;
        end else if (complete) begin
            syn_valid <= 1'b1;
            syn_out   <= syn_d;
            syn_zero  <= all_zero;
        end else if (syn_ready) begin
            syn_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_rs_syndrome_seq.sv
// Bench for rs_syndrome_seq (default RS(18,16) config; framing tests when RS_SYN_FRAMING_EN).
// Reference model evaluates the received polynomial directly at each root.
module tb_rs_syndrome_seq;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic [7:0]  in_data = '0;
    logic        in_ready;
    logic        syn_valid;
    logic        syn_zero;
    logic [15:0] syn_out;
    logic        syn_ready;
    logic        fixed_ready = 1'b0;
    logic        rand_ready = 1'b0;
    logic        rnd_bit;
`ifdef RS_SYN_FRAMING_EN
    logic        in_sop = 1'b0;
    logic        frame_err;
`endif

    assign syn_ready = rand_ready ? rnd_bit : fixed_ready;

    always #5 clk = ~clk;
    always @(posedge clk) rnd_bit <= ($urandom_range(0, 2) != 0);

    rs_syndrome_seq #(
        .SYMBOL_WIDTH (8),
        .N            (18),
        .NSYN         (2),
        .FCR          (1),
        .PRIM_POLY    (9'h11D)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
`ifdef RS_SYN_FRAMING_EN
        .in_sop    (in_sop),
        .frame_err (frame_err),
`endif
        .syn_valid (syn_valid),
        .syn_ready (syn_ready),
        .syn_out   (syn_out),
        .syn_zero  (syn_zero)
    );

    int unsigned n_tests = 0;
    int unsigned n_fail  = 0;
    logic [16:0] exp_q[$];
    bit          sb_en = 1'b0;
    bit          stall_prev = 1'b0;
    logic [16:0] held;

    typedef struct {
        logic [143:0] cw;
        logic [15:0]  syn;
        logic         zero;
    } vec_t;
    vec_t vecs[5];

    function automatic logic [7:0] m_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, aa;
        logic       c;
        p  = '0;
        aa = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p ^= aa;
            c  = aa[7];
            aa = aa << 1;
            if (c) aa ^= 8'h1D;
        end
        return p;
    endfunction

    // cw[8i +: 8] holds r_i; returns {all_zero, S0, S1}
    function automatic logic [16:0] model(input logic [143:0] cw);
        logic [7:0] s [2];
        logic [7:0] root, pw;
        for (int j = 0; j < 2; j++) begin
            root = 8'h01;
            for (int e = 0; e < 1 + j; e++) root = m_mul(root, 8'h02);
            s[j] = '0;
            pw   = 8'h01;
            for (int i = 0; i < 18; i++) begin
                s[j] ^= m_mul(cw[i*8 +: 8], pw);
                pw = m_mul(pw, root);
            end
        end
        return {(s[0] == 8'h00) && (s[1] == 8'h00), s[0], s[1]};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic at_negedge();
        logic [16:0] e;
        @(negedge clk);
        if (sb_en) begin
            if (stall_prev)
                check("hold", {syn_valid, syn_zero, syn_out}, {1'b1, held});
            if (syn_valid && syn_ready) begin
                if (exp_q.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL spurious_syn: got %h expected none", {syn_zero, syn_out});
                end else begin
                    e = exp_q.pop_front();
                    check("sb_syn", {syn_zero, syn_out}, e);
                end
            end
            stall_prev = syn_valid && !syn_ready;
            held       = {syn_zero, syn_out};
        end
    endtask

    task automatic step();
        at_negedge();
        @(posedge clk);
        #1;
    endtask

    task automatic send_sym(input logic [7:0] d, input bit sop);
        int t;
        t        = 0;
        in_valid = 1'b1;
        in_data  = d;
`ifdef RS_SYN_FRAMING_EN
        in_sop   = sop;
`endif
        at_negedge();
        while (!in_ready && t < 200) begin
            @(posedge clk);
            #1;
            at_negedge();
            t++;
        end
        if (!in_ready) begin
            n_tests++;
            n_fail++;
            $display("FAIL in_ready_timeout: got 0 expected 1 within 200 cycles");
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
`ifdef RS_SYN_FRAMING_EN
        in_sop   = 1'b0;
`endif
    endtask

    task automatic send_cw(input logic [143:0] cw, input bit gaps);
        for (int k = 0; k < 18; k++) begin
            if (gaps) repeat ($urandom_range(0, 2)) step();
            send_sym(cw[(17-k)*8 +: 8], k == 0);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout: got hang expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic [143:0] cw;
        logic [16:0]  m;
        bit           flag;
        int           t;

        vecs[0] = '{144'h0, 16'h0000, 1'b1};
        vecs[1] = '{144'h01, 16'h0101, 1'b0};
        vecs[2] = '{{8'h01, 136'h0}, 16'h984E, 1'b0};
        for (int v = 3; v < 5; v++) begin
            for (int b = 0; b < 18; b++) cw[b*8 +: 8] = 8'($urandom);
            m = model(cw);
            vecs[v] = '{cw, m[15:0], m[16]};
        end

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_syn_valid", syn_valid, 0);
        check("rst_syn_out", syn_out, 0);
        check("rst_syn_zero", syn_zero, 0);
        check("rst_in_ready", in_ready, 1);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Table vectors: result visible one cycle after the last symbol
        fixed_ready = 1'b1;
        for (int v = 0; v < 5; v++) begin
            send_cw(vecs[v].cw, 1'b0);
            check("tbl_valid", syn_valid, 1);
            check("tbl_syn", syn_out, vecs[v].syn);
            check("tbl_zero", syn_zero, vecs[v].zero);
            step();
            check("tbl_clear", syn_valid, 0);
        end

        // Back-to-back with downstream stalled
        fixed_ready = 1'b0;
        send_cw(144'h0, 1'b0);
        check("b2b_first_valid", syn_valid, 1);
        flag = 1'b0;
        for (int k = 0; k < 17; k++) begin
            in_valid = 1'b1;
            in_data  = 8'h00;
`ifdef RS_SYN_FRAMING_EN
            in_sop   = (k == 0);
`endif
            at_negedge();
            if (!in_ready) flag = 1'b1;
            @(posedge clk);
            #1;
        end
`ifdef RS_SYN_FRAMING_EN
        in_sop = 1'b0;
`endif
        check("b2b_no_early_stall", flag, 0);
        in_data = 8'h01;
        at_negedge();
        check("b2b_last_stall", in_ready, 0);
        check("b2b_hold_syn", {syn_valid, syn_zero, syn_out}, 18'h30000);
        @(posedge clk);
        #1;
        at_negedge();
        check("b2b_still_stall", in_ready, 0);
        check("b2b_still_hold", {syn_valid, syn_zero, syn_out}, 18'h30000);
        @(posedge clk);
        #1;
        fixed_ready = 1'b1;
        at_negedge();
        check("b2b_release", in_ready, 1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        check("b2b_second_valid", syn_valid, 1);
        check("b2b_second_syn", {syn_zero, syn_out}, 17'h00101);
        step();
        check("b2b_clear", syn_valid, 0);

        // Reset mid-codeword
        for (int k = 0; k < 9; k++) send_sym(8'($urandom_range(1, 255)), k == 0);
        rst_n = 1'b0;
        step();
        check("midrst_valid", syn_valid, 0);
        step();
        rst_n = 1'b1;
        flag = 1'b0;
        cw = {8'h01, 136'h0};
        for (int k = 0; k < 17; k++) begin
            send_sym(cw[(17-k)*8 +: 8], k == 0);
            if (syn_valid) flag = 1'b1;
        end
        check("midrst_no_spurious", flag, 0);
        send_sym(8'h00, 1'b0);
        check("midrst_syn", {syn_valid, syn_out}, 17'h1984E);
        step();

`ifdef RS_SYN_FRAMING_EN
        // Early SOP aborts the partial codeword
        for (int k = 0; k < 5; k++) send_sym(8'($urandom_range(1, 255)), k == 0);
        check("sop_no_err_yet", frame_err, 0);
        flag = 1'b0;
        send_sym(8'h00, 1'b1);
        check("sop_err_pulse", frame_err, 1);
        for (int k = 1; k < 17; k++) begin
            send_sym(8'h00, 1'b0);
            if (frame_err || syn_valid) flag = 1'b1;
        end
        check("sop_single_pulse", flag, 0);
        send_sym(8'h01, 1'b0);
        check("sop_syn", {syn_valid, syn_zero, syn_out}, 18'h20101);
        step();
        // Symbol without SOP between codewords is dropped
        send_sym(8'hAA, 1'b0);
        check("nosop_err", frame_err, 1);
        send_cw({8'h01, 136'h0}, 1'b0);
        check("nosop_syn", {syn_valid, syn_out}, 17'h1984E);
        step();
`endif

        // Randomized traffic with random backpressure against the model
        stall_prev = 1'b0;
        sb_en      = 1'b1;
        rand_ready = 1'b1;
        for (int n = 0; n < 25; n++) begin
            for (int b = 0; b < 18; b++) cw[b*8 +: 8] = 8'($urandom);
            if (n == 7) cw = '0;
            exp_q.push_back(model(cw));
            send_cw(cw, 1'b1);
        end
        fixed_ready = 1'b1;
        rand_ready  = 1'b0;
        t = 0;
        while (exp_q.size() != 0 && t < 100) begin
            step();
            t++;
        end
        check("drain_left", exp_q.size(), 0);
        step();
        sb_en = 1'b0;
        check("final_idle", syn_valid, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
